// File: rtl/riio_pwr_pkg.sv
// Shared types and sizing for the IO-ring power-segment sequencer.
package riio_pwr_pkg;

   localparam int MAX_NSEG = 16;
   localparam int IDX_W    = 4;

   typedef enum logic [3:0] {
      ST_OFF,
      ST_UP_SW,
      ST_UP_SETTLE,
      ST_UP_ISO,
      ST_ON,
      ST_DN_ISO,
      ST_DN_SETTLE,
      ST_DN_SW,
      ST_ERR
   } pwr_state_e;

endpackage

// File: rtl/riio_pwr_seg_seq_sync2.sv
// Two-flop synchroniser bank for the asynchronous switch-chain acknowledges.
module riio_sync2 #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/riio_pwr_seg_seq.sv
// Power-segment sequencer: ordered switch-on/iso-release and iso/switch-off of NSEG ring segments.
// Optional ack-wait timeout with ERR state when RIIO_PWR_SEQ_TIMEOUT_EN is defined.
//
// state        | meaning
// OFF          | all segments off and isolated, idle
// UP_SW        | enable switch idx (or skip if masked), wait for its ack
// UP_SETTLE    | settle count after ack, then release iso idx
// UP_ISO       | step to next segment or to ON
// ON           | all masked-in segments powered, idle
// DN_ISO       | isolate segment idx (or skip if masked)
// DN_SETTLE    | settle count before switching idx off
// DN_SW        | disable switch idx, wait for ack to drop, step down
// ERR          | ack timeout, failing segment forced off
module riio_pwr_seg_seq
   import riio_pwr_pkg::*;
#(
   parameter int NSEG        = 4,
   parameter int SETTLE_CYC  = 16,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_on_i,
   input  logic [NSEG-1:0]  seg_mask_i,
   input  logic [NSEG-1:0]  sw_ack_i,
   input  logic             err_clr_i,
   output logic [NSEG-1:0]  sw_en_o,
   output logic [NSEG-1:0]  iso_o,
   output logic             busy_o,
   output logic             on_o,
   output logic             err_o,
   output logic [IDX_W-1:0] err_seg_o
);

   localparam int SEL_W   = (NSEG > 1) ? $clog2(NSEG) : 1;
   localparam int CNT_MAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [IDX_W-1:0] LAST     = IDX_W'(NSEG - 1);
   localparam logic [CNT_W-1:0] SET_LOAD = CNT_W'(SETTLE_CYC - 1);
`ifdef RIIO_PWR_SEQ_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(TIMEOUT_CYC - 1);
`endif

   pwr_state_e       state_q;
   logic [IDX_W-1:0] idx_q;
   logic [SEL_W-1:0] sel;
   logic [CNT_W-1:0] cnt_q;
   logic [NSEG-1:0]  mask_q;
   logic [NSEG-1:0]  sw_en_q;
   logic [NSEG-1:0]  iso_q;
   logic [NSEG-1:0]  ack_s;
   logic             busy_q;
   logic             on_q;
   logic             err_q;
   logic [IDX_W-1:0] err_seg_q;

   riio_sync2 #(.W(NSEG)) u_ack_sync (
      .clk (clk),
      .rst (rst),
      .d_i (sw_ack_i),
      .q_o (ack_s)
   );

   assign sel = idx_q[SEL_W-1:0];

   // The mask latched at power-up also drives power-down, so exactly the segments
   // that were brought up are taken down.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_OFF;
         idx_q     <= '0;
         cnt_q     <= '0;
         mask_q    <= '0;
         sw_en_q   <= '0;
         iso_q     <= '1;
         busy_q    <= 1'b0;
         on_q      <= 1'b0;
         err_q     <= 1'b0;
         err_seg_q <= '0;
      end else begin
         unique case (state_q)
            ST_OFF: begin
               if (req_on_i) begin
                  mask_q  <= seg_mask_i;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_UP_SW;
               end
            end
            ST_UP_SW: begin
               if (!mask_q[sel]) begin
                  if (idx_q == LAST) begin
                     on_q    <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= ST_ON;
                  end else begin
                     idx_q <= idx_q + IDX_W'(1);
                  end
               end else if (!sw_en_q[sel]) begin
                  sw_en_q[sel] <= 1'b1;
`ifdef RIIO_PWR_SEQ_TIMEOUT_EN
                  cnt_q <= TO_LOAD;
`endif
               end else if (ack_s[sel]) begin
                  cnt_q   <= SET_LOAD;
                  state_q <= ST_UP_SETTLE;
               end
`ifdef RIIO_PWR_SEQ_TIMEOUT_EN
               else if (cnt_q == '0) begin
                  sw_en_q[sel] <= 1'b0;
                  iso_q[sel]   <= 1'b1;
                  busy_q       <= 1'b0;
                  err_q        <= 1'b1;
                  err_seg_q    <= idx_q;
                  state_q      <= ST_ERR;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
`endif
            end
            ST_UP_SETTLE: begin
               if (cnt_q == '0) begin
                  iso_q[sel] <= 1'b0;
                  state_q    <= ST_UP_ISO;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            ST_UP_ISO: begin
               if (idx_q == LAST) begin
                  on_q    <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= ST_ON;
               end else begin
                  idx_q   <= idx_q + IDX_W'(1);
                  state_q <= ST_UP_SW;
               end
            end
            ST_ON: begin
               if (!req_on_i) begin
                  idx_q   <= LAST;
                  on_q    <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= ST_DN_ISO;
               end
            end
            ST_DN_ISO: begin
               if (!mask_q[sel]) begin
                  if (idx_q == '0) begin
                     busy_q  <= 1'b0;
                     state_q <= ST_OFF;
                  end else begin
                     idx_q <= idx_q - IDX_W'(1);
                  end
               end else begin
                  iso_q[sel] <= 1'b1;
                  cnt_q      <= SET_LOAD;
                  state_q    <= ST_DN_SETTLE;
               end
            end
            ST_DN_SETTLE: begin
               if (cnt_q == '0) begin
                  state_q <= ST_DN_SW;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            ST_DN_SW: begin
               if (sw_en_q[sel]) begin
                  sw_en_q[sel] <= 1'b0;
`ifdef RIIO_PWR_SEQ_TIMEOUT_EN
                  cnt_q <= TO_LOAD;
`endif
               end else if (!ack_s[sel]) begin
                  if (idx_q == '0) begin
                     busy_q  <= 1'b0;
                     state_q <= ST_OFF;
                  end else begin
                     idx_q   <= idx_q - IDX_W'(1);
                     state_q <= ST_DN_ISO;
                  end
               end
`ifdef RIIO_PWR_SEQ_TIMEOUT_EN
               else if (cnt_q == '0) begin
                  iso_q[sel] <= 1'b1;
                  busy_q     <= 1'b0;
                  err_q      <= 1'b1;
                  err_seg_q  <= idx_q;
                  state_q    <= ST_ERR;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
`endif
            end
            ST_ERR: begin
               if (err_clr_i && !req_on_i) begin
                  err_q   <= 1'b0;
                  state_q <= ST_OFF;
               end
            end
            default: state_q <= ST_OFF;
         endcase
      end
   end

   assign sw_en_o   = sw_en_q;
   assign iso_o     = iso_q;
   assign busy_o    = busy_q;
   assign on_o      = on_q;
   assign err_o     = err_q;
   assign err_seg_o = err_seg_q;

endmodule

// File: tb/tb_riio_pwr_seg_seq.sv
// Scoreboard bench: expected output-change events (value and spacing) queued at stimulus time.
module tb_riio_pwr_seg_seq;

   localparam int NSEG   = 4;
   localparam int SETTLE = 4;
   localparam int TOUT   = 8;

   typedef struct {
      string      tag;
      logic [9:0] val;
      int         dt;
   } ev_t;

   logic            clk;
   logic            rst;
   logic            req_on;
   logic [NSEG-1:0] seg_mask;
   logic [NSEG-1:0] stuck;
   logic [NSEG-1:0] sw_ack;
   logic            err_clr;
   logic [NSEG-1:0] sw_en;
   logic [NSEG-1:0] iso;
   logic            busy;
   logic            on_w;
   logic            err;
   logic [3:0]      err_seg;

   int   n_chk = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   int   last  = 0;
   bit   mon_en = 0;
   logic [9:0] prev;
   ev_t  q[$];

   logic [3:0] m_sw;
   logic [3:0] m_iso;
   logic       m_on;
   logic       m_busy;

   riio_pwr_seg_seq #(.NSEG(NSEG), .SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TOUT)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_on_i   (req_on),
      .seg_mask_i (seg_mask),
      .sw_ack_i   (sw_ack),
      .err_clr_i  (err_clr),
      .sw_en_o    (sw_en),
      .iso_o      (iso),
      .busy_o     (busy),
      .on_o       (on_w),
      .err_o      (err),
      .err_seg_o  (err_seg)
   );

   assign sw_ack = sw_en & ~stuck;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic void push(input string tag, input int dt);
      ev_t e;
      e.tag = tag;
      e.val = {m_on, m_busy, m_sw, m_iso};
      e.dt  = dt;
      q.push_back(e);
   endfunction

   function automatic void push_up(input logic [3:0] mask);
      int gap;
      m_busy = 1'b1;
      push("up_busy", 1);
      gap = 1;
      for (int i = 0; i < NSEG; i++) begin
         if (!mask[i]) gap++;
         else begin
            m_sw[i] = 1'b1;
            push($sformatf("up_sw%0d", i), gap);
            m_iso[i] = 1'b0;
            push($sformatf("up_iso%0d", i), 3 + SETTLE);
            gap = 2;
         end
      end
      m_on   = 1'b1;
      m_busy = 1'b0;
      push("up_on", gap - 1);
   endfunction

   function automatic void push_down(input logic [3:0] mask);
      int gap;
      m_on   = 1'b0;
      m_busy = 1'b1;
      push("dn_start", 1);
      gap = 1;
      for (int i = NSEG - 1; i >= 0; i--) begin
         if (!mask[i]) gap++;
         else begin
            m_iso[i] = 1'b1;
            push($sformatf("dn_iso%0d", i), gap);
            m_sw[i] = 1'b0;
            push($sformatf("dn_sw%0d", i), SETTLE + 1);
            gap = 4;
         end
      end
      m_busy = 1'b0;
      push("dn_off", gap - 1);
   endfunction

   // Every change of the output tuple must match the next queued event.
   always @(negedge clk) begin
      logic [9:0] cur;
      ev_t e;
      cur = {on_w, busy, sw_en, iso};
      if (mon_en && cur !== prev) begin
         if (q.size() == 0) begin
            chk("unexp_chg", {22'd0, cur}, {22'd0, prev});
         end else begin
            e = q.pop_front();
            chk({e.tag, "_val"}, {22'd0, cur}, {22'd0, e.val});
            chk({e.tag, "_dt"}, cyc - last, e.dt);
         end
         prev = cur;
         last = cyc;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic drain(input string tag, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (q.size() == 0) break;
         step();
      end
      chk({tag, "_drain"}, q.size(), 0);
      repeat (3) step();
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1);
   end

   initial begin
      rst = 1'b1; req_on = 1'b0; seg_mask = 4'hF; stuck = '0; err_clr = 1'b0;
      m_sw = '0; m_iso = '1; m_on = 1'b0; m_busy = 1'b0;
      repeat (3) step();
      chk("rst_sw", sw_en, 4'h0);
      chk("rst_iso", iso, 4'hF);
      chk("rst_busy", busy, 0);
      chk("rst_on", on_w, 0);
      chk("rst_err", err, 0);
      chk("rst_errseg", err_seg, 0);
      rst = 1'b0;
      step();
      prev = {on_w, busy, sw_en, iso};
      last = cyc;
      mon_en = 1'b1;

      // full power-up then power-down
      seg_mask = 4'hF; req_on = 1'b1; last = cyc;
      push_up(4'hF);
      drain("up1111", 300);
      chk("up_on_o", on_w, 1);
      chk("up_busy_o", busy, 0);
      chk("up_iso_o", iso, 4'h0);
      req_on = 1'b0; last = cyc;
      push_down(4'hF);
      drain("dn1111", 300);
      chk("dn_sw_o", sw_en, 4'h0);
      chk("dn_iso_o", iso, 4'hF);

      // partial mask
      seg_mask = 4'b0101; req_on = 1'b1; last = cyc;
      push_up(4'b0101);
      step();
      seg_mask = 4'hF;
      drain("up0101", 300);
      chk("m0101_iso", iso, 4'b1010);
      chk("m0101_sw", sw_en, 4'b0101);
      req_on = 1'b0; last = cyc;
      push_down(4'b0101);
      drain("dn0101", 300);

      // all-zero mask walks to ON without output change
      seg_mask = 4'h0; req_on = 1'b1; last = cyc;
      push_up(4'h0);
      drain("up0000", 100);
      req_on = 1'b0; last = cyc;
      push_down(4'h0);
      drain("dn0000", 100);

      // request dropped mid power-up
      seg_mask = 4'hF; req_on = 1'b1; last = cyc;
      push_up(4'hF);
      repeat (10) step();
      req_on = 1'b0;
      push_down(4'hF);
      drain("toggle", 400);
      chk("toggle_on", on_w, 0);
      chk("toggle_busy", busy, 0);

      // reset in UP_SETTLE of segment 2
      req_on = 1'b1; last = cyc;
      push_up(4'hF);
      for (int i = 0; i < 300; i++) begin
         step();
         if (sw_en[2]) break;
      end
      chk("sw2_seen", sw_en[2], 1);
      repeat (4) step();
      chk("rst_pending", q.size(), 4);
      q.delete();
      rst = 1'b1; req_on = 1'b0; last = cyc;
      m_sw = '0; m_iso = '1; m_on = 1'b0; m_busy = 1'b0;
      push("midrst", 1);
      step();
      rst = 1'b0;
      chk("midrst_sw", sw_en, 4'h0);
      chk("midrst_iso", iso, 4'hF);
      chk("midrst_busy", busy, 0);
      drain("midrst", 10);

`ifdef RIIO_PWR_SEQ_TIMEOUT_EN
      // segment 1 ack stuck low
      stuck = 4'b0010; seg_mask = 4'hF; req_on = 1'b1; last = cyc;
      m_busy = 1'b1; push("to_busy", 1);
      m_sw[0] = 1'b1; push("to_sw0", 1);
      m_iso[0] = 1'b0; push("to_iso0", 3 + SETTLE);
      m_sw[1] = 1'b1; push("to_sw1", 2);
      m_sw[1] = 1'b0; m_busy = 1'b0; push("to_err", TOUT);
      drain("timeout", 300);
      chk("to_err_o", err, 1);
      chk("to_errseg", err_seg, 1);
      chk("to_iso1", iso[1], 1);
      err_clr = 1'b1; step(); err_clr = 1'b0; step();
      chk("to_clr_held", err, 1);
      req_on = 1'b0;
      err_clr = 1'b1; step(); err_clr = 1'b0; step();
      chk("to_clr_err", err, 0);
      chk("to_clr_busy", busy, 0);
      drain("to_end", 10);
`else
      chk("no_to_err", err, 0);
      chk("no_to_errseg", err_seg, 0);
`endif

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
